bus_mem_ctrl: RTL and testbench
===============================

Name: bus_mem_ctrl

Overview:
- Sits directly downstream of the snooping bus and upstream of d_mem.
- Accepts single-word fill reads and dirty write-backs from the bus for either CPU.
- Buffers write-backs in a small coalescing write buffer and serves reads from that buffer when the address hits.
- Sequences all other accesses onto the d_mem re/we/rdy handshake and returns fill data tagged with the requesting CPU.

Parameters:
- ADDR_W, 11, word address width; matches the bus address width.
- DATA_W, 16, data word width.
- WB_DEPTH, 2, number of write-buffer entries; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  bus presents a request.
- req_ready  out  1  controller accepts the request this cycle.
- req_wr  in  1  1 = write-back, 0 = fill read.
- req_cpu  in  1  requesting CPU id (0/1).
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write-back data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse: fill data valid.
- rsp_cpu  out  1  CPU id of the returned fill.
- rsp_rdata  out  DATA_W  fill data.
- wb_empty  out  1  write buffer empty and no write in flight; memory is coherent.
- mem_addr  out  ADDR_W  d_mem address.
- mem_re  out  1  d_mem read enable.
- mem_we  out  1  d_mem write enable.
- mem_wdata  out  DATA_W  d_mem write data.
- mem_rdata  in  DATA_W  d_mem read data, valid when mem_rdy.
- mem_rdy  in  1  d_mem completes the current access.

Behaviour:
- Reset values: state IDLE; buffer emptied; req_ready=0 during the rst cycle, 1 the following cycle. rsp_valid=0, rsp_cpu=0, rsp_rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_empty=1.
- Reset mid-operation drops the in-flight access and all buffered write-backs. mem_re/mem_we are low the cycle after rst is sampled.
- States: IDLE, RD_WAIT, WR_WAIT. All outputs are registered.
- req_ready = (state==IDLE) && !buffer_full && !rst. It does not depend on req_valid or req_wr.
- Accept occurs on req_valid && req_ready.
- Write accept (IDLE):
  - If req_addr matches a buffered entry, overwrite that entry's data (coalesce; count unchanged).
  - Otherwise push at the tail.
  - State stays IDLE. No response is generated.
- Read accept, buffer hit (IDLE):
  - Next cycle: rsp_valid=1, rsp_rdata=buffered data, rsp_cpu=req_cpu.
  - State stays IDLE. Latency is 1 cycle. Entries are unique after coalescing, so the hit is unambiguous.
- Read accept, buffer miss (IDLE):
  - Next cycle: mem_addr=req_addr, mem_re=1, state RD_WAIT. req_cpu is latched.
- RD_WAIT:
  - Hold mem_re, mem_addr stable until mem_rdy.
  - On mem_rdy: next cycle mem_re=0, rsp_valid=1, rsp_rdata=mem_rdata as sampled with mem_rdy, rsp_cpu=latched id, state IDLE.
  - Read latency = accept cycle + d_mem wait cycles + 1.
- Drain (IDLE):
  - Condition: no accept this cycle and buffer non-empty.
  - Next cycle: mem_addr/mem_wdata = head entry, mem_we=1, state WR_WAIT.
  - An accepted request always wins over drain in the same cycle.
  - buffer_full forces req_ready=0, so drain is guaranteed; no starvation.
- WR_WAIT:
  - Hold mem_we, mem_addr, mem_wdata until mem_rdy.
  - On mem_rdy: retire the head entry (pop), mem_we=0 next cycle, state IDLE.
  - The head stays forwardable until retired. Reads cannot be accepted during WR_WAIT because req_ready=0.
- mem_re and mem_we are never high in the same cycle.
- Buffer is a circular FIFO with head/tail pointers that wrap modulo WB_DEPTH, plus a count (0..WB_DEPTH).
- wb_empty = (count==0) && state!=WR_WAIT.
- rsp_valid is high for exactly one cycle per accepted read. There is no response backpressure; the bus must sink it.
- mem_rdy is ignored in IDLE.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 one cycle, then idle.
  - Required: all outputs 0 except wb_empty=1; req_ready=1 the cycle after rst drops.
- Read miss with 3-cycle d_mem:
  - Stimulus: read addr 0x05A, cpu=1; d_mem asserts mem_rdy on its 3rd cycle with data 0xBEEF.
  - Required: mem_re high exactly 3 cycles, addr 0x05A; rsp_valid pulse with rsp_cpu=1, rsp_rdata=0xBEEF one cycle after mem_rdy.
- Write-back forwarding:
  - Stimulus: write 0x010←0x1234, then next cycle read 0x010, cpu=0.
  - Required: rsp_valid one cycle after the read accept with rsp_rdata=0x1234, rsp_cpu=0; no mem_re. Afterwards the drain issues mem_we with 0x010/0x1234.
- Coalescing:
  - Stimulus: write 0x020←0x1111, then write 0x020←0x2222 back-to-back.
  - Required: exactly one mem_we, carrying 0x2222; wb_empty returns to 1 after mem_rdy.
- Buffer full (WB_DEPTH=2):
  - Stimulus: writes to 0x001, 0x002, with req_valid held on a 3rd write to 0x003.
  - Required: req_ready=0 until the first drain retires on mem_rdy; the drain order is 0x001, 0x002, 0x003.
- Reset during RD_WAIT:
  - Stimulus: rst asserted with mem_re high.
  - Required: mem_re=0 and no rsp_valid next cycle; buffer empty, wb_empty=1.

Source files
------------

// File: rtl/bus_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_ctrl
// Purpose  : Bus-to-d_mem controller that coalesces and forwards write-backs
//            and sequences fill reads onto the d_mem re/we/rdy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bus_mem_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int WB_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_cpu,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_cpu,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wb_empty,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy
);

    localparam int c_PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(WB_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Write buffer storage: circular FIFO with a per-entry valid bit for lookup
    logic [ADDR_W-1:0]  r_ent_addr [WB_DEPTH];
    logic [DATA_W-1:0]  r_ent_data [WB_DEPTH];
    logic [WB_DEPTH-1:0] r_vld;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               r_cpu;
    logic               r_rsp_valid;
    logic               r_rsp_cpu;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_wb_empty;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_re;
    logic               r_mem_we;
    logic [DATA_W-1:0]  r_mem_wdata;

    logic               w_full;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_hit;
    logic [c_PTR_W-1:0] w_hit_idx;
    logic [DATA_W-1:0]  w_hit_data;
    logic               w_push;
    logic               w_coal;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_head_inc;
    logic [c_PTR_W-1:0] w_tail_inc;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_cpu_nxt;
    logic               w_rsp_valid_nxt;
    logic               w_rsp_cpu_nxt;
    logic [DATA_W-1:0]  w_rsp_rdata_nxt;
    logic               w_wb_empty_nxt;
    logic [ADDR_W-1:0]  w_mem_addr_nxt;
    logic               w_mem_re_nxt;
    logic               w_mem_we_nxt;
    logic [DATA_W-1:0]  w_mem_wdata_nxt;

    assign w_full      = (r_count == c_CNT_W'(WB_DEPTH));
    assign w_req_ready = (r_state == IDLE) && !w_full && !rst;
    assign w_accept    = req_valid && w_req_ready;

    assign w_head_inc  = (r_head == c_PTR_W'(WB_DEPTH - 1)) ? '0 : r_head + 1'b1;
    assign w_tail_inc  = (r_tail == c_PTR_W'(WB_DEPTH - 1)) ? '0 : r_tail + 1'b1;

    // Entries are unique after coalescing, so at most one can match
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (r_vld[i] && (r_ent_addr[i] == req_addr)) begin
                w_hit      = 1'b1;
                w_hit_idx  = c_PTR_W'(i);
                w_hit_data = r_ent_data[i];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_push          = 1'b0;
        w_coal          = 1'b0;
        w_pop           = 1'b0;
        w_cpu_nxt       = r_cpu;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_cpu_nxt   = r_rsp_cpu;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_re_nxt    = r_mem_re;
        w_mem_we_nxt    = r_mem_we;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_wr) begin
                        w_coal = w_hit;
                        w_push = !w_hit;
                    end else if (w_hit) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = w_hit_data;
                        w_rsp_cpu_nxt   = req_cpu;
                    end else begin
                        w_mem_addr_nxt = req_addr;
                        w_mem_re_nxt   = 1'b1;
                        w_cpu_nxt      = req_cpu;
                        w_state_nxt    = RD_WAIT;
                    end
                end else if (r_count != '0) begin
                    w_mem_addr_nxt  = r_ent_addr[r_head];
                    w_mem_wdata_nxt = r_ent_data[r_head];
                    w_mem_we_nxt    = 1'b1;
                    w_state_nxt     = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rdy) begin
                    w_mem_re_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = mem_rdata;
                    w_rsp_cpu_nxt   = r_cpu;
                    w_state_nxt     = IDLE;
                end
            end
            WR_WAIT: begin
                // Head stays valid (forwardable) until d_mem completes it
                if (mem_rdy) begin
                    w_mem_we_nxt = 1'b0;
                    w_pop        = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_mem_re_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
                w_state_nxt  = IDLE;
            end
        endcase
        w_count_nxt    = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        w_wb_empty_nxt = (w_count_nxt == '0) && (w_state_nxt != WR_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld       <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_cpu       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_cpu   <= 1'b0;
            r_rsp_rdata <= '0;
            r_wb_empty  <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_cpu       <= w_cpu_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_cpu   <= w_rsp_cpu_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_wb_empty  <= w_wb_empty_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_re    <= w_mem_re_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            if (w_push) begin
                r_ent_addr[r_tail] <= req_addr;
                r_ent_data[r_tail] <= req_wdata;
                r_vld[r_tail]      <= 1'b1;
                r_tail             <= w_tail_inc;
            end
            if (w_coal) begin
                r_ent_data[w_hit_idx] <= req_wdata;
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= w_head_inc;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_cpu   = r_rsp_cpu;
    assign rsp_rdata = r_rsp_rdata;
    assign wb_empty  = r_wb_empty;
    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_mem_ctrl
// Purpose  : Directed self-checking bench for bus_mem_ctrl with a d_mem model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_mem_ctrl;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 16;
    localparam int WB_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wr = 1'b0;
    logic              req_cpu = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_cpu;
    logic [DATA_W-1:0] rsp_rdata;
    logic              wb_empty;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    // d_mem model: completes each access on its mem_lat-th cycle
    int                mem_lat = 3;
    int                lat_cnt = 0;
    logic [DATA_W-1:0] rd_val  = 16'hBEEF;
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [DATA_W-1:0] wr_data_q [$];
    int                both_cnt = 0;

    // observation results
    int                re_cnt;
    int                rsp_cnt;
    int                rsp_idx;
    logic [ADDR_W-1:0] re_addr;
    logic              rsp_cpu_s;
    logic [DATA_W-1:0] rsp_data_s;

    assign mem_rdata = rd_val;
    assign mem_rdy   = (mem_re || mem_we) && (lat_cnt == mem_lat - 1);

    always @(posedge clk) begin
        if (rst || !(mem_re || mem_we) || mem_rdy) lat_cnt <= 0;
        else                                       lat_cnt <= lat_cnt + 1;
        if (!rst && mem_we && mem_rdy) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    always @(negedge clk) begin
        if (mem_re === 1'b1 && mem_we === 1'b1) both_cnt <= both_cnt + 1;
    end

    always #5 clk = ~clk;

    bus_mem_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_cpu   (req_cpu),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_cpu   (rsp_cpu),
        .rsp_rdata (rsp_rdata),
        .wb_empty  (wb_empty),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input logic cpu,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid = v;
        req_wr    = wr;
        req_cpu   = cpu;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Sample n cycles; index 0 is the point just after the current edge
    task automatic observe(input int n);
        re_cnt     = 0;
        rsp_cnt    = 0;
        rsp_idx    = -1;
        re_addr    = '0;
        rsp_cpu_s  = 1'b0;
        rsp_data_s = '0;
        for (int i = 0; i < n; i++) begin
            if (mem_re) begin
                re_cnt++;
                re_addr = mem_addr;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_idx < 0) rsp_idx = i;
                rsp_cpu_s  = rsp_cpu;
                rsp_data_s = rsp_rdata;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_tests++; if (rsp_cpu !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_cpu: got %b want 0", rsp_cpu); end
        n_tests++; if (rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_tests++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got re=%b we=%b want 0/0", mem_re, mem_we); end
        n_tests++; if (mem_addr !== 11'h0 || mem_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
        n_tests++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL reset_wb_empty: got %b want 1", wb_empty); end
        rst = 1'b0;
        tick();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_read_miss();
        mem_lat = 3;
        rd_val  = 16'hBEEF;
        drive(1'b1, 1'b0, 1'b1, 11'h05A, 16'h0);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL miss_req_ready: got %b want 1", req_ready); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        observe(10);
        n_tests++; if (re_cnt !== 3) begin n_fail++; $display("FAIL miss_re_cycles: got %0d want 3", re_cnt); end
        n_tests++; if (re_addr !== 11'h05A) begin n_fail++; $display("FAIL miss_addr: got %h want 05a", re_addr); end
        n_tests++; if (rsp_cnt !== 1) begin n_fail++; $display("FAIL miss_rsp_count: got %0d want 1", rsp_cnt); end
        n_tests++; if (rsp_idx !== 3) begin n_fail++; $display("FAIL miss_rsp_latency: got %0d want 3", rsp_idx); end
        n_tests++; if (rsp_cpu_s !== 1'b1) begin n_fail++; $display("FAIL miss_rsp_cpu: got %b want 1", rsp_cpu_s); end
        n_tests++; if (rsp_data_s !== 16'hBEEF) begin n_fail++; $display("FAIL miss_rsp_data: got %h want beef", rsp_data_s); end
    endtask

    task automatic test_forwarding();
        mem_lat = 2;
        wr_addr_q.delete();
        wr_data_q.delete();
        drive(1'b1, 1'b1, 1'b0, 11'h010, 16'h1234);
        tick();
        drive(1'b1, 1'b0, 1'b0, 11'h010, 16'h0);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_req_ready: got %b want 1", req_ready); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        observe(10);
        n_tests++; if (rsp_idx !== 0 || rsp_cnt !== 1) begin n_fail++; $display("FAIL fwd_rsp_timing: got idx=%0d cnt=%0d want 0/1", rsp_idx, rsp_cnt); end
        n_tests++; if (rsp_data_s !== 16'h1234 || rsp_cpu_s !== 1'b0) begin n_fail++; $display("FAIL fwd_rsp_data: got %h cpu=%b want 1234 cpu=0", rsp_data_s, rsp_cpu_s); end
        n_tests++; if (re_cnt !== 0) begin n_fail++; $display("FAIL fwd_no_mem_re: got %0d want 0", re_cnt); end
        n_tests++; if (wr_addr_q.size() !== 1) begin n_fail++; $display("FAIL fwd_drain_count: got %0d want 1", wr_addr_q.size()); end
        else begin
            n_tests++; if (wr_addr_q[0] !== 11'h010 || wr_data_q[0] !== 16'h1234) begin n_fail++; $display("FAIL fwd_drain: got %h/%h want 010/1234", wr_addr_q[0], wr_data_q[0]); end
        end
        n_tests++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL fwd_wb_empty: got %b want 1", wb_empty); end
    endtask

    task automatic test_coalesce();
        mem_lat = 2;
        wr_addr_q.delete();
        wr_data_q.delete();
        drive(1'b1, 1'b1, 1'b0, 11'h020, 16'h1111);
        tick();
        n_tests++; if (wb_empty !== 1'b0) begin n_fail++; $display("FAIL coal_wb_busy: got %b want 0", wb_empty); end
        drive(1'b1, 1'b1, 1'b1, 11'h020, 16'h2222);
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        observe(10);
        n_tests++; if (wr_addr_q.size() !== 1) begin n_fail++; $display("FAIL coal_we_count: got %0d want 1", wr_addr_q.size()); end
        else begin
            n_tests++; if (wr_addr_q[0] !== 11'h020 || wr_data_q[0] !== 16'h2222) begin n_fail++; $display("FAIL coal_data: got %h/%h want 020/2222", wr_addr_q[0], wr_data_q[0]); end
        end
        n_tests++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL coal_wb_empty: got %b want 1", wb_empty); end
    endtask

    task automatic test_buffer_full();
        int rdy_idx;
        int wq_at_rdy;
        logic [ADDR_W-1:0] ea [3];
        logic [DATA_W-1:0] ed [3];
        ea[0] = 11'h001; ea[1] = 11'h002; ea[2] = 11'h003;
        ed[0] = 16'hA001; ed[1] = 16'hA002; ed[2] = 16'hA003;
        mem_lat = 2;
        wr_addr_q.delete();
        wr_data_q.delete();
        drive(1'b1, 1'b1, 1'b0, ea[0], ed[0]);
        tick();
        drive(1'b1, 1'b1, 1'b0, ea[1], ed[1]);
        tick();
        drive(1'b1, 1'b1, 1'b1, ea[2], ed[2]);
        rdy_idx   = -1;
        wq_at_rdy = -1;
        for (int i = 0; i < 20 && rdy_idx < 0; i++) begin
            if (req_ready) begin
                rdy_idx   = i;
                wq_at_rdy = wr_addr_q.size();
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        observe(20);
        n_tests++; if (rdy_idx !== 3) begin n_fail++; $display("FAIL full_ready_cycle: got %0d want 3", rdy_idx); end
        n_tests++; if (wq_at_rdy !== 1) begin n_fail++; $display("FAIL full_retired_before_ready: got %0d want 1", wq_at_rdy); end
        n_tests++; if (wr_addr_q.size() !== 3) begin n_fail++; $display("FAIL full_drain_count: got %0d want 3", wr_addr_q.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (wr_addr_q[k] !== ea[k] || wr_data_q[k] !== ed[k]) begin
                    n_fail++;
                    $display("FAIL full_drain_order[%0d]: got %h/%h want %h/%h", k, wr_addr_q[k], wr_data_q[k], ea[k], ed[k]);
                end
            end
        end
        n_tests++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL full_wb_empty: got %b want 1", wb_empty); end
    endtask

    task automatic test_reset_rd_wait();
        mem_lat = 8;
        wr_addr_q.delete();
        wr_data_q.delete();
        drive(1'b1, 1'b1, 1'b0, 11'h030, 16'h5555);
        tick();
        drive(1'b1, 1'b0, 1'b1, 11'h100, 16'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        tick();
        n_tests++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL rstrd_mem_re_before: got %b want 1", mem_re); end
        rst = 1'b1;
        tick();
        n_tests++; if (mem_re !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstrd_after_reset: got re=%b rsp=%b want 0/0", mem_re, rsp_valid); end
        n_tests++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL rstrd_wb_empty: got %b want 1", wb_empty); end
        rst = 1'b0;
        mem_lat = 2;
        observe(10);
        n_tests++; if (wr_addr_q.size() !== 0 || rsp_cnt !== 0 || re_cnt !== 0) begin n_fail++; $display("FAIL rstrd_dropped: got we=%0d rsp=%0d re=%0d want 0/0/0", wr_addr_q.size(), rsp_cnt, re_cnt); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_forwarding();
        test_coalesce();
        test_buffer_full();
        test_reset_rd_wait();
        n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL re_we_exclusive: got %0d overlap cycles want 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
